// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, point values and ghost-combo width,
// reused by the game controller, ghost and graphics blocks.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DYING = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } game_state_e;

    localparam int COMBO_W = 2;
    localparam int SCORE_W = 20;

    localparam logic [COMBO_W-1:0] COMBO_MAX         = 2'd3;
    localparam logic [SCORE_W-1:0] PELLET_POINTS     = 20'd10;
    localparam logic [SCORE_W-1:0] POWER_POINTS      = 20'd50;
    localparam logic [SCORE_W-1:0] GHOST_BASE_POINTS = 20'd200;
    localparam logic [SCORE_W-1:0] SCORE_MAX         = 20'd999999;
    localparam logic [SCORE_W-1:0] EXTRA_LIFE_SCORE  = 20'd10000;
    localparam logic [2:0]         MAX_LIVES         = 3'd7;

    function automatic logic [SCORE_W-1:0] ghost_award(input logic [COMBO_W-1:0] combo);
        return GHOST_BASE_POINTS << combo;
    endfunction

endpackage

// File: rtl/fright_timer.sv
// Frightened-mode timer and ghost-combo tracker; also prices the ghosts
// eaten this tick so the controller can add them to the score.
module fright_timer
    import game_pkg::*;
#(
    parameter int FRIGHT_TICKS = 360
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               play,
    input  logic               hold,
    input  logic               power_eaten,
    input  logic [3:0]         ghost_eaten,
    input  logic               clear,
    output logic               fright_active,
    output logic [COMBO_W-1:0] ghost_combo,
    output logic [SCORE_W-1:0] ghost_points
);

    localparam int TW = $clog2(FRIGHT_TICKS + 1);

    logic [TW-1:0]      timer_q, timer_d;
    logic [COMBO_W-1:0] combo_q, combo_d, combo_walk;
    logic               active_q;

    // Award ghosts in ascending bit order, each at the combo left by the previous one.
    always_comb begin
        ghost_points = '0;
        combo_walk   = combo_q;
        for (int i = 0; i < 4; i++) begin
            ghost_points = ghost_points +
                ((play && active_q && ghost_eaten[i]) ? ghost_award(combo_walk) : 20'd0);
            combo_walk   = (play && active_q && ghost_eaten[i] && combo_walk != COMBO_MAX) ?
                           combo_walk + 2'd1 : combo_walk;
        end
    end

    // Timer reload, hold-aware countdown, and combo reset on reload or expiry.
    always_comb begin
        if (clear) begin
            timer_d = '0;
        end else if (play && power_eaten) begin
            timer_d = TW'(FRIGHT_TICKS);
        end else if (play && !hold && timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end else begin
            timer_d = timer_q;
        end

        if (clear || (play && power_eaten) || timer_d == '0) begin
            combo_d = '0;
        end else begin
            combo_d = combo_walk;
        end
    end

    // Timer, combo and frightened-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            combo_q  <= '0;
            active_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            combo_q  <= combo_d;
            active_q <= (timer_d != '0);
        end
    end

    assign fright_active = active_q;
    assign ghost_combo   = combo_q;

endmodule

// File: rtl/game_state.sv
// Top-level game controller: game-flow FSM, score, lives, level and pellet
// bookkeeping, with the frightened-mode logic in fright_timer.
module game_state
    import game_pkg::*;
#(
    parameter int TOTAL_PELLETS = 244,
    parameter int FRIGHT_TICKS  = 360,
    parameter int READY_TICKS   = 120,
    parameter int DEATH_TICKS   = 120,
    parameter int CLEAR_TICKS   = 180,
    parameter int START_LIVES   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic [3:0]  ghost_eaten,
    input  logic        pacman_caught,
    output logic [2:0]  state,
    output logic        pause,
    output logic [19:0] score,
    output logic [2:0]  lives,
    output logic [7:0]  level,
    output logic [7:0]  pellets_left,
    output logic        fright_active,
    output logic [1:0]  ghost_combo,
    output logic        maze_reload
);

    localparam logic [15:0] READY_LOAD = 16'(READY_TICKS - 1);
    localparam logic [15:0] DEATH_LOAD = 16'(DEATH_TICKS - 1);
    localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_TICKS - 1);

    game_state_e        state_q;
    logic [15:0]        tick_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d, lives_bonus_s;
    logic [7:0]         level_q, pellets_q, pellets_d;
    logic               bonus_q, reload_q, start_q, pause_q;
    logic               in_play_s, start_edge_s, level_done_s, caught_s, bonus_grant_s;
    logic [1:0]         eaten_cnt_s;
    logic [SCORE_W:0]   score_sum_s;
    logic [SCORE_W-1:0] ghost_points_s;

    assign in_play_s    = (state_q == ST_PLAY);
    assign start_edge_s = start & ~start_q;
    assign eaten_cnt_s  = {1'b0, pellet_eaten} + {1'b0, power_eaten};
    assign pellets_d    = (pellets_q > {6'd0, eaten_cnt_s}) ? pellets_q - {6'd0, eaten_cnt_s} : 8'd0;
    // Clearing the maze wins over a same-tick catch; the fright timer is dropped on either exit.
    assign level_done_s = in_play_s && (eaten_cnt_s != 2'd0) && (pellets_d == 8'd0);
    assign caught_s     = in_play_s && pacman_caught && !level_done_s;

    assign score_sum_s = {1'b0, score_q}
                       + {1'b0, (pellet_eaten ? PELLET_POINTS : 20'd0)}
                       + {1'b0, (power_eaten  ? POWER_POINTS  : 20'd0)}
                       + {1'b0, ghost_points_s};
    assign score_d       = (score_sum_s > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum_s[SCORE_W-1:0];
    assign bonus_grant_s = !bonus_q && (score_d >= EXTRA_LIFE_SCORE);
    assign lives_bonus_s = (bonus_grant_s && lives_q != MAX_LIVES) ? lives_q + 3'd1 : lives_q;
    assign lives_d       = caught_s ? lives_bonus_s - 3'd1 : lives_bonus_s;

    fright_timer #(
        .FRIGHT_TICKS(FRIGHT_TICKS)
    ) u_fright (
        .clk          (clk),
        .rst          (rst),
        .play         (in_play_s),
        .hold         (hold),
        .power_eaten  (power_eaten),
        .ghost_eaten  (ghost_eaten),
        .clear        (level_done_s || caught_s),
        .fright_active(fright_active),
        .ghost_combo  (ghost_combo),
        .ghost_points (ghost_points_s)
    );

    // Game-flow FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= 16'd0;
            score_q   <= '0;
            lives_q   <= 3'd0;
            level_q   <= 8'd0;
            pellets_q <= 8'd0;
            bonus_q   <= 1'b0;
            reload_q  <= 1'b0;
            start_q   <= 1'b0;
            pause_q   <= 1'b1;
        end else begin
            start_q  <= start;
            reload_q <= 1'b0;
            pause_q  <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        state_q   <= ST_READY;
                        tick_q    <= READY_LOAD;
                        lives_q   <= 3'(START_LIVES);
                        score_q   <= '0;
                        level_q   <= 8'd1;
                        pellets_q <= 8'(TOTAL_PELLETS);
                        bonus_q   <= 1'b0;
                        reload_q  <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (!hold) begin
                        if (tick_q == 16'd0) begin
                            state_q <= ST_PLAY;
                            pause_q <= 1'b0;
                        end else begin
                            tick_q <= tick_q - 16'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    score_q   <= score_d;
                    lives_q   <= lives_d;
                    bonus_q   <= bonus_q | bonus_grant_s;
                    pellets_q <= pellets_d;
                    if (level_done_s) begin
                        state_q <= ST_CLEAR;
                        tick_q  <= CLEAR_LOAD;
                    end else if (caught_s) begin
                        state_q <= ST_DYING;
                        tick_q  <= DEATH_LOAD;
                    end else begin
                        pause_q <= hold;
                    end
                end
                ST_DYING: begin
                    if (!hold) begin
                        if (tick_q == 16'd0) begin
                            state_q <= (lives_q != 3'd0) ? ST_READY : ST_OVER;
                            tick_q  <= READY_LOAD;
                        end else begin
                            tick_q <= tick_q - 16'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (!hold) begin
                        if (tick_q == 16'd0) begin
                            state_q   <= ST_READY;
                            tick_q    <= READY_LOAD;
                            level_q   <= level_q + 8'd1;
                            pellets_q <= 8'(TOTAL_PELLETS);
                            reload_q  <= 1'b1;
                        end else begin
                            tick_q <= tick_q - 16'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (start_edge_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign pause        = pause_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign pellets_left = pellets_q;
    assign maze_reload  = reload_q;

endmodule

// File: doc/game_state.md
GAME_STATE -- requirements
Module: game_state

Interface
REQ-001 SHALL have parameters: TOTAL_PELLETS, default 244, pellets per maze; FRIGHT_TICKS, default 360, frightened duration in ticks; READY_TICKS, default 120, pre-play delay; DEATH_TICKS, default 120, death animation hold; CLEAR_TICKS, default 180, level-clear hold; START_LIVES, default 3.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  game tick clock (60 Hz gameclk)
- rst  in  1  synchronous, active-high reset
- start  in  1  start button level
- hold  in  1  ghost-score freeze; stalls all timers
- pellet_eaten  in  1  one-tick pulse, pellet consumed
- power_eaten  in  1  one-tick pulse, power pellet consumed
- ghost_eaten  in  4  per-ghost one-tick pulses {clyde,inky,pinky,blinky}
- pacman_caught  in  1  one-tick pulse, ghost touched non-frightened pacman
- state  out  3  current game state encoding
- pause  out  1  high whenever state != PLAY or hold=1
- score  out  20  binary score
- lives  out  3  remaining lives
- level  out  8  current level
- pellets_left  out  8  pellets remaining
- fright_active  out  1  frightened mode
- ghost_combo  out  2  award index for next ghost (0=200 .. 3=1600)
- maze_reload  out  1  one-tick pulse, restore pellets in maze

Function
REQ-003 SHALL implement states IDLE, READY, PLAY, DYING, CLEAR, OVER.
REQ-004 IDLE: on start=1 -> READY; load lives=START_LIVES, score=0, level=1, pellets_left=TOTAL_PELLETS; pulse maze_reload.
REQ-005 READY: count READY_TICKS ticks, then -> PLAY.
REQ-006 PLAY: pellet_eaten adds 10, decrements pellets_left; power_eaten adds 50, decrements pellets_left, loads fright timer with FRIGHT_TICKS, clears ghost_combo.
REQ-007 Each ghost_eaten bit while fright_active adds 200<<ghost_combo, then ghost_combo increments, saturating at 3; multiple bits in one tick are awarded in ascending combo order (4 bits from combo 0 = 3000 total).
REQ-008 ghost_eaten when fright_active=0 SHALL be ignored.
REQ-009 Fright timer decrements by 1 each PLAY tick with hold=0; fright_active = timer != 0; timer expiry clears ghost_combo.
REQ-010 Score SHALL saturate at 999999.
REQ-011 First crossing of score >= 10000 SHALL add one life (once per game); lives saturate at 7.
REQ-012 pacman_caught in PLAY: lives decrements, fright timer clears, -> DYING.
REQ-013 pellets_left reaching 0 in PLAY -> CLEAR; takes priority over pacman_caught in the same tick (points still awarded).
REQ-014 DYING: hold DEATH_TICKS; then lives>0 -> READY (pellets retained), lives=0 -> OVER.
REQ-015 CLEAR: hold CLEAR_TICKS; then level increments (wraps 255->0), pellets_left reloads, maze_reload pulses, -> READY.
REQ-016 OVER: start rising edge -> IDLE; score held for display until then.
REQ-017 start in IDLE/OVER SHALL be edge-detected; a held button SHALL NOT skip OVER.
REQ-018 hold=1 SHALL freeze all state timers and the fright timer; pellet/ghost events still scored.
REQ-019 Events outside PLAY SHALL be ignored.
REQ-020 Outputs registered; every event reflected on outputs one tick after its pulse.

Reset
REQ-021 rst=1 at any clock edge, including mid-fright or mid-DYING: state=IDLE, score=0, lives=0, level=0, pellets_left=0, fright timer=0, ghost_combo=0, maze_reload=0, pause=1, extra-life flag cleared.

Structure
REQ-022 State encoding, point values, and combo width SHALL live in shared package game_pkg, reused by ghost and graphics blocks.
REQ-023 Fright timer and combo logic SHALL be sub-module fright_timer.

Verification
REQ-024 Reset, start pulse, 120 ticks -> state PLAY, lives=3, pellets_left=244, score=0, maze_reload seen once.
REQ-025 Power pulse, then ghost_eaten=4'b1111 in one tick -> score 50+3000=3050, ghost_combo=3; after 360 ticks fright_active=0, ghost_combo=0.
REQ-026 Score 9990, pellet pulse -> score 10000, lives 4; further crossings add no life.
REQ-027 lives=1, pacman_caught -> DYING, 120 ticks -> OVER; start held continuously stays OVER until released and re-pressed.
REQ-028 pellets_left=1, pellet and pacman_caught same tick -> CLEAR, lives unchanged, after 180 ticks level=2, pellets_left=244.
REQ-029 hold=1 for 50 ticks mid-fright -> timer value unchanged; rst mid-DYING -> all outputs at REQ-021 values next tick.
